// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
package dmem_pkg;

   localparam int unsigned DMEM_WORD_W   = 32;
   localparam int unsigned DMEM_CNT_W    = 16;
   localparam logic [31:0] DMEM_ERR_WORD = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      ERR  = 2'd2
   } dmem_state_e;

   function automatic logic dmem_is_aligned(input logic [31:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/dmem_sat_cnt.sv
// Saturating up-counter with enable and synchronous active-high reset.
module dmem_sat_cnt
   import dmem_pkg::*;
#(
   parameter int unsigned WIDTH = DMEM_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with registered 1-cycle read response and error pulses.
// Optional access statistics enabled by defining DMEM_STATS_EN.
module data_mem_resp
   import dmem_pkg::*;
#(
   parameter int unsigned             DEPTH    = 64,
   parameter logic [DMEM_WORD_W-1:0]  ERR_WORD = DMEM_ERR_WORD
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            address,
   input  logic [DMEM_WORD_W-1:0] memIn,
   input  logic                   read,
   input  logic                   write,
   output logic [DMEM_WORD_W-1:0] memOut,
   output logic                   rvalid,
   output logic                   err,
   output logic [DMEM_CNT_W-1:0]  rd_count,
   output logic [DMEM_CNT_W-1:0]  wr_count,
   output logic [DMEM_CNT_W-1:0]  err_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DMEM_WORD_W-1:0] r_mem [DEPTH];
   dmem_state_e            r_state;
   dmem_state_e            w_state_nxt;
   logic [DMEM_WORD_W-1:0] r_mem_out;
   logic [DMEM_WORD_W-1:0] w_mem_out_nxt;
   logic                   r_err_rd;

   logic [29:0]   w_word_idx;
   logic [AW-1:0] w_idx;
   logic          w_aligned;
   logic          w_in_range;
   logic          w_rd_ok;
   logic          w_wr_ok;
   logic          w_reject;
   logic          w_rd_rej;

   // Range check uses the full word index so upper-bit overflow never aliases.
   assign w_word_idx = address[31:2];
   assign w_idx      = w_word_idx[AW-1:0];
   assign w_aligned  = dmem_is_aligned(address);
   assign w_in_range = (32'(w_word_idx) < DEPTH);

   assign w_rd_ok  = read  & ~write & w_aligned & w_in_range;
   assign w_wr_ok  = write & ~read  & w_aligned & w_in_range;
   assign w_reject = (read | write) & ~(w_rd_ok | w_wr_ok);
   assign w_rd_rej = w_reject & read;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[w_idx] <= memIn;
      end
   end

   always_comb begin
      w_state_nxt   = IDLE;
      w_mem_out_nxt = r_mem_out;
      if (w_rd_ok) begin
         w_state_nxt   = RESP;
         w_mem_out_nxt = r_mem[w_idx];
      end else if (w_reject) begin
         w_state_nxt = ERR;
         if (w_rd_rej) begin
            w_mem_out_nxt = ERR_WORD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_mem_out <= '0;
         r_err_rd  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_mem_out <= w_mem_out_nxt;
         r_err_rd  <= w_rd_rej;
      end
   end

   assign memOut = r_mem_out;
   assign err    = (r_state == ERR);
   assign rvalid = (r_state == RESP) | ((r_state == ERR) & r_err_rd);

`ifdef DMEM_STATS_EN
   dmem_sat_cnt #(
      .WIDTH (DMEM_CNT_W)
   ) u_rd_cnt (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (w_rd_ok),
      .o_count (rd_count)
   );

   dmem_sat_cnt #(
      .WIDTH (DMEM_CNT_W)
   ) u_wr_cnt (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (w_wr_ok),
      .o_count (wr_count)
   );

   dmem_sat_cnt #(
      .WIDTH (DMEM_CNT_W)
   ) u_err_cnt (
      .i_clk   (clk),
      .i_reset (reset),
      .i_en    (w_reject),
      .o_count (err_count)
   );
`else
   assign rd_count  = '0;
   assign wr_count  = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp with a behavioural reference model and per-cycle compare.
module tb_data_mem_resp;

   localparam int unsigned DEPTH    = 64;
   localparam logic [31:0] ERR_WORD = 32'hDEADBEEF;
`ifdef DMEM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] address;
   logic [31:0] memIn;
   logic        read;
   logic        write;
   logic [31:0] memOut;
   logic        rvalid;
   logic        err;
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   logic [15:0] err_count;

   data_mem_resp #(
      .DEPTH    (DEPTH),
      .ERR_WORD (ERR_WORD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .memIn     (memIn),
      .read      (read),
      .write     (write),
      .memOut    (memOut),
      .rvalid    (rvalid),
      .err       (err),
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   // Reference model state: expected outputs after the most recent edge.
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_out;
   bit          m_rvalid;
   bit          m_err;
   int          m_rd;
   int          m_wr;
   int          m_ec;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   task automatic model_edge(input bit rst, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] data);
      bit ok;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_out = '0; m_rvalid = 0; m_err = 0; m_rd = 0; m_wr = 0; m_ec = 0;
         return;
      end
      ok = (addr % 4 == 0) && ((addr / 4) < DEPTH) && (rd != wr);
      m_rvalid = 0;
      m_err    = 0;
      if (!rd && !wr) return;
      if (!ok) begin
         m_err    = 1;
         m_rvalid = rd;
         if (rd) m_out = ERR_WORD;
         m_ec = sat_inc(m_ec);
      end else if (rd) begin
         m_out    = m_mem[addr / 4];
         m_rvalid = 1;
         m_rd     = sat_inc(m_rd);
      end else begin
         m_mem[addr / 4] = data;
         m_wr = sat_inc(m_wr);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("memOut", memOut, m_out);
         check("rvalid", 32'(rvalid), 32'(m_rvalid));
         check("err", 32'(err), 32'(m_err));
         check("rd_count", 32'(rd_count), STATS ? 32'(m_rd) : 32'd0);
         check("wr_count", 32'(wr_count), STATS ? 32'(m_wr) : 32'd0);
         check("err_count", 32'(err_count), STATS ? 32'(m_ec) : 32'd0);
      end
   end

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input bit rst, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
      reset = rst; read = rd; write = wr; address = addr; memIn = data;
      @(posedge clk);
      model_edge(rst, rd, wr, addr, data);
      chk_en = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; memIn = '0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("rst_memOut", memOut, 32'h0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      step(0, 0, 1, 16, 32'h12345678);
      check("wr_no_pulse", 32'(rvalid | err), 32'd0);
      step(0, 0, 1, 24, 32'h89abcdef);
      step(0, 1, 0, 16, 0);
      check("rd16", memOut, 32'h12345678);
      check("rd16_rvalid", 32'(rvalid), 32'd1);
      step(0, 1, 0, 20, 0);
      check("rd20", memOut, 32'h00000000);
      step(0, 1, 0, 24, 0);
      check("rd24", memOut, 32'h89abcdef);
      step(0, 0, 0, 0, 0);
      check("idle_rvalid", 32'(rvalid), 32'd0);
      check("idle_hold", memOut, 32'h89abcdef);

      step(0, 1, 0, 18, 0);
      check("misal_err", 32'(err), 32'd1);
      check("misal_rvalid", 32'(rvalid), 32'd1);
      check("misal_data", memOut, 32'hDEADBEEF);
      check("stat_rd", 32'(rd_count), STATS ? 32'd3 : 32'd0);
      check("stat_wr", 32'(wr_count), STATS ? 32'd2 : 32'd0);
      check("stat_err", 32'(err_count), STATS ? 32'd1 : 32'd0);

      step(0, 0, 1, DEPTH * 4, 32'hCAFEF00D);
      check("oor_err", 32'(err), 32'd1);
      check("oor_rvalid", 32'(rvalid), 32'd0);
      step(0, 1, 0, 0, 0);
      check("rd0", memOut, 32'h00000000);

      step(0, 1, 1, 16, 32'h1);
      check("rw_err", 32'(err), 32'd1);
      check("rw_data", memOut, 32'hDEADBEEF);
      step(0, 1, 0, 16, 0);
      check("rd16_after_rw", memOut, 32'h12345678);

      // Upper address bits set: must not alias onto word 4.
      step(0, 0, 1, 32'h4000_0010, 32'h55555555);
      check("ovf_err", 32'(err), 32'd1);
      step(0, 1, 0, 16, 0);
      check("rd16_after_ovf", memOut, 32'h12345678);

      step(0, 0, 1, 24, 32'hA5A5A5A5);
      step(0, 1, 0, 24, 0);
      check("raw24", memOut, 32'hA5A5A5A5);

      for (int i = 0; i < 8; i++) step(0, 0, 1, 32'(i * 8), 32'(i) * 32'h01010101);
      for (int i = 0; i < 8; i++) step(0, 1, 0, 32'(i * 8), 0);
      step(0, 1, 0, 32'h0000_0002, 0);
      step(0, 1, 0, (DEPTH - 1) * 4, 0);
      step(0, 1, 0, DEPTH * 4, 0);
      step(0, 0, 0, 0, 0);

      step(0, 1, 0, 16, 0);
      step(1, 1, 0, 16, 0);
      check("rst_kills_rvalid", 32'(rvalid), 32'd0);

      step(0, 0, 1, 16, 32'h77777777);
      step(1, 1, 0, 16, 0);
      check("rst_drop_rvalid", 32'(rvalid), 32'd0);
      check("rst_drop_memOut", memOut, 32'h0);
      step(0, 1, 0, 16, 0);
      check("rd16_after_rst", memOut, 32'h00000000);
      check("rd16_after_rst_rv", 32'(rvalid), 32'd1);
      step(0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 64, memory depth in 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter ERR_WORD, default 32'hDEADBEEF, the data returned on a failed read.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address  input  32  byte address of the access.
REQ-006 memIn  input  32  write data.
REQ-007 read  input  1  read request, sampled at rising clk.
REQ-008 write  input  1  write request, sampled at rising clk.
REQ-009 memOut  output  32  registered read data.
REQ-010 rvalid  output  1  one-cycle pulse marking memOut valid.
REQ-011 err  output  1  one-cycle pulse marking a rejected request.
REQ-012 rd_count, wr_count, err_count  output  16 each  access statistics.

Function
REQ-013 SHALL classify each request at a rising edge as valid only if address[1:0]==0 and address[31:2] < DEPTH.
REQ-014 Valid write (write=1, read=0): SHALL store memIn at word address[31:2] at that edge; no output pulse.
REQ-015 Valid read (read=1, write=0): SHALL drive memOut with the stored word and pulse rvalid for the cycle after the edge (1-cycle latency).
REQ-016 Read after write to the same word on consecutive edges SHALL return the new data.
REQ-017 Rejected request (misaligned, out of range, or read=write=1): SHALL not modify memory, SHALL pulse err the following cycle, and on a read-type reject SHALL also pulse rvalid with memOut=ERR_WORD.
REQ-018 read=write=1 SHALL count as a read-type reject.
REQ-019 Idle (read=write=0): rvalid=err=0; memOut SHALL hold its last value.
REQ-020 FSM states: IDLE, RESP, ERR; each edge SHALL move to RESP on a valid read, ERR on any reject, otherwise IDLE. RESP and ERR SHALL last exactly one cycle unless a new request re-enters them; back-to-back requests every cycle SHALL be accepted with no stall.
REQ-021 Word index SHALL use address[31:2]; upper-bit overflow SHALL be rejected, never wrap into the array.

Reset
REQ-022 While reset=1 at an edge: state=IDLE, memOut=0, rvalid=0, err=0, all counters=0, all memory words=0.
REQ-023 A request sampled in the same edge as reset=1 SHALL be dropped (no write, no pulse, no count).
REQ-024 A read accepted the edge before reset SHALL have its rvalid cleared by reset.

Configuration
REQ-025 Macro DMEM_STATS_EN: when defined, rd_count/wr_count/err_count SHALL increment on each valid read, valid write and reject respectively, saturating at 16'hFFFF.
REQ-026 Without DMEM_STATS_EN the counter ports SHALL remain present and be tied to 0; no counter flops are inferred.

Structure
REQ-027 Shared package dmem_pkg SHALL hold the FSM state typedef (IDLE, RESP, ERR), the ERR_WORD default and the word-width constant 32.
REQ-028 One sub-module, dmem_sat_cnt (16-bit saturating counter with enable and sync reset), SHALL be instantiated three times under DMEM_STATS_EN.

Verification
REQ-029 Write 32'h12345678 @16, write 32'h89abcdef @24, read 16/20/24 -> memOut 12345678, 00000000, 89abcdef, each with rvalid one cycle after the request.
REQ-030 Read @18 (misaligned) -> cycle after: err=1, rvalid=1, memOut=DEADBEEF; memory unchanged.
REQ-031 Write 32'hCAFEF00D @DEPTH*4 -> err pulse; subsequent read @0 returns 00000000.
REQ-032 read=write=1 @16 with memIn=32'h1 -> err+rvalid, memOut=DEADBEEF; read @16 still returns 12345678.
REQ-033 Write @16, assert reset on next edge with read @16 -> no rvalid; after reset, read @16 returns 00000000.
REQ-034 With DMEM_STATS_EN: 2 writes, 3 reads, 1 reject -> wr_count=2, rd_count=3, err_count=1; without the macro all read 0.
